// File: rtl/sha256_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

  localparam int         BLOCK_W       = 512;
  localparam int         LEN_FIELD_W   = 64;
  localparam logic [7:0] PAD_BYTE      = 8'h80;
  localparam int         BYTES_PER_BLK = 64;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_FILL,
    ST_PAD,
    ST_EMIT,
    ST_DONE
  } pad_state_t;

endpackage

// File: rtl/sha256_rd_pipe.sv
// Tracks outstanding SRAM reads: carries {valid, block byte index} alongside
// the SRAM latency so returning data lands in the byte it was issued for.
module sha256_rd_pipe #(
  parameter int LAT = 1
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       flush,
  input  logic       in_valid,
  input  logic [5:0] in_idx,
  output logic       out_valid,
  output logic [5:0] out_idx
);

  logic       vld_q [LAT];
  logic [5:0] idx_q [LAT];

  // Shift the read tag forward one stage per cycle; flush drops in-flight reads.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < LAT; i++) begin
        vld_q[i] <= 1'b0;
        idx_q[i] <= '0;
      end
    end else begin
      vld_q[0] <= in_valid & ~flush;
      idx_q[0] <= in_idx;
      for (int i = 1; i < LAT; i++) begin
        vld_q[i] <= vld_q[i-1] & ~flush;
        idx_q[i] <= idx_q[i-1];
      end
    end
  end

  assign out_valid = vld_q[LAT-1];
  assign out_idx   = idx_q[LAT-1];

endmodule

// File: rtl/sha256_msg_padder.sv
// Streams a byte message from SRAM into SHA-256 padded 512-bit blocks.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for start
// CLEAR    | zero the block buffer, decide whether this block has data
// FILL     | issue SRAM reads for this block, wait for the pipe to drain
// PAD      | insert 0x80 marker and, on the final block, the bit length
// EMIT     | present block until accepted
// DONE     | one-cycle done pulse, busy already low
module sha256_msg_padder
  import sha256_pkg::*;
#(
  parameter int LEN_W   = 10,
  parameter int MEM_LAT = 1
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic [LEN_W-1:0]   msg_len,
  input  logic               abort,
  output logic               mem_en,
  output logic [LEN_W-1:0]   mem_addr,
  input  logic [7:0]         mem_data,
  output logic               blk_valid,
  input  logic               blk_ready,
  output logic [BLOCK_W-1:0] blk_data,
  output logic               blk_last,
  output logic               busy,
  output logic               done
);

  pad_state_t       state;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-6:0] blk_idx;
  logic [5:0]       rd_k;
  logic [2:0]       drain_cnt;

  logic             rd_valid;
  logic [5:0]       rd_idx;

  // Block position arithmetic is one bit wider than the length so a
  // maximum-length message never wraps.
  logic [LEN_W:0]   blk_base;
  logic [LEN_W:0]   len_ext;
  logic [LEN_W:0]   pad_off;
  logic [LEN_W+1:0] len_p8;
  logic [LEN_W+1:0] blk_end;
  logic [LEN_W-1:0] len_last;
  logic             data_left;
  logic             pad_here;
  logic             blk_is_last;

  assign blk_base    = {blk_idx, 6'b000000};
  assign len_ext     = {1'b0, len_q};
  assign pad_off     = len_ext - blk_base;
  assign len_p8      = {2'b00, len_q} + (LEN_W+2)'(8);
  assign blk_end     = {1'b0, blk_base} + (LEN_W+2)'(BYTES_PER_BLK);
  assign len_last    = len_q - 1'b1;
  assign data_left   = blk_base < len_ext;
  assign pad_here    = (len_ext >= blk_base) && (pad_off[LEN_W:6] == '0);
  // Final block is the one whose end lies beyond the marker plus length field.
  assign blk_is_last = len_p8 < blk_end;

  sha256_rd_pipe #(.LAT(MEM_LAT)) u_rd_pipe (
    .clock     (clock),
    .reset_n   (reset_n),
    .flush     (abort),
    .in_valid  (mem_en),
    .in_idx    (rd_k),
    .out_valid (rd_valid),
    .out_idx   (rd_idx)
  );

  // Padder FSM with registered SRAM, block and status outputs.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      len_q     <= '0;
      blk_idx   <= '0;
      rd_k      <= '0;
      drain_cnt <= '0;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_data  <= '0;
      blk_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else if (abort) begin
      state     <= ST_IDLE;
      mem_en    <= 1'b0;
      mem_addr  <= '0;
      blk_valid <= 1'b0;
      blk_last  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          done  <= 1'b0;
          state <= ST_IDLE;
          if (start) begin
            len_q   <= msg_len;
            blk_idx <= '0;
            busy    <= 1'b1;
            state   <= ST_CLEAR;
          end
        end
        ST_CLEAR: begin
          blk_data <= '0;
          if (data_left) begin
            mem_en   <= 1'b1;
            mem_addr <= blk_base[LEN_W-1:0];
            rd_k     <= '0;
            state    <= ST_FILL;
          end else begin
            state <= ST_PAD;
          end
        end
        ST_FILL: begin
          if (rd_valid) blk_data[{~rd_idx, 3'b111} -: 8] <= mem_data;
          if (mem_en) begin
            if (rd_k == 6'd63 || mem_addr == len_last) begin
              mem_en    <= 1'b0;
              mem_addr  <= '0;
              drain_cnt <= 3'(MEM_LAT);
            end else begin
              mem_addr <= mem_addr + 1'b1;
              rd_k     <= rd_k + 1'b1;
            end
          end else if (drain_cnt == 3'd1) begin
            state <= ST_PAD;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_PAD: begin
          if (pad_here) blk_data[{~pad_off[5:0], 3'b111} -: 8] <= PAD_BYTE;
          if (blk_is_last) blk_data[LEN_FIELD_W-1:0] <= LEN_FIELD_W'({len_q, 3'b000});
          blk_last  <= blk_is_last;
          blk_valid <= 1'b1;
          state     <= ST_EMIT;
        end
        ST_EMIT: begin
          if (blk_ready) begin
            blk_valid <= 1'b0;
            if (blk_last) begin
              blk_last <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= ST_DONE;
            end else begin
              blk_idx <= blk_idx + 1'b1;
              state   <= ST_CLEAR;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: two instances (read latency 1 and 3) share the
// stimulus; a behavioural padding model checks every presented block.
module tb_sha256_msg_padder;

  localparam int LEN_W = 10;
  localparam logic [511:0] ABC_LIT = {32'h61626380, 416'h0, 64'h18};
  localparam logic [511:0] L0_LIT  = {8'h80, 440'h0, 64'h0};
  localparam logic [511:0] L56_B1  = {448'h0, 64'h1C0};
  localparam logic [511:0] L64_B1  = {8'h80, 440'h0, 64'h200};

  logic clock = 1'b0;
  logic reset_n = 1'b1;
  logic start = 1'b0, abort = 1'b0, blk_ready = 1'b0;
  logic [LEN_W-1:0] msg_len = '0;
  int sel = 0;

  logic start0, start1, abort0, abort1;
  logic me0, me1, bv0, bv1, bl0, bl1, bu0, bu1, dn0, dn1;
  logic [LEN_W-1:0] ma0, ma1;
  logic [7:0] md0, md1;
  logic [511:0] bd0, bd1;

  logic [7:0] mem [1024];
  logic [7:0] p0 [1];
  logic [7:0] p1 [3];

  logic c_valid, c_last, c_busy, c_done, c_mem_en;
  logic [LEN_W-1:0] c_mem_addr;
  logic [511:0] c_data;

  int tests = 0, fails = 0;
  int cyc = 0;
  int rdy_mode = 0;
  bit chk_en = 0;
  int cur_len = 0, nblk = 1, exp_blk = 0, rd_exp = 0, first_v = -1, start_cyc = 0, done_cnt = 0;
  bit held = 0, prev_last = 0;
  logic [511:0] prev_data;
  logic [511:0] cap_blk [32];

  assign start0 = start && (sel == 0);
  assign start1 = start && (sel != 0);
  assign abort0 = abort && (sel == 0);
  assign abort1 = abort && (sel != 0);

  assign c_valid    = (sel != 0) ? bv1 : bv0;
  assign c_last     = (sel != 0) ? bl1 : bl0;
  assign c_busy     = (sel != 0) ? bu1 : bu0;
  assign c_done     = (sel != 0) ? dn1 : dn0;
  assign c_mem_en   = (sel != 0) ? me1 : me0;
  assign c_mem_addr = (sel != 0) ? ma1 : ma0;
  assign c_data     = (sel != 0) ? bd1 : bd0;

  sha256_msg_padder #(.LEN_W(LEN_W), .MEM_LAT(1)) dut0 (
    .clock(clock), .reset_n(reset_n), .start(start0), .msg_len(msg_len), .abort(abort0),
    .mem_en(me0), .mem_addr(ma0), .mem_data(md0), .blk_valid(bv0), .blk_ready(blk_ready),
    .blk_data(bd0), .blk_last(bl0), .busy(bu0), .done(dn0));

  sha256_msg_padder #(.LEN_W(LEN_W), .MEM_LAT(3)) dut1 (
    .clock(clock), .reset_n(reset_n), .start(start1), .msg_len(msg_len), .abort(abort1),
    .mem_en(me1), .mem_addr(ma1), .mem_data(md1), .blk_valid(bv1), .blk_ready(blk_ready),
    .blk_data(bd1), .blk_last(bl1), .busy(bu1), .done(dn1));

  initial forever #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  // SRAM models: garbage on data when no read was issued.
  assign md0 = p0[0];
  assign md1 = p1[2];
  always @(posedge clock) begin
    p0[0] <= me0 ? mem[ma0] : 8'($urandom);
    p1[0] <= me1 ? mem[ma1] : 8'($urandom);
    p1[1] <= p1[0];
    p1[2] <= p1[1];
  end

  task automatic check(input bit ok, input string nm, input logic [511:0] act, input logic [511:0] exp);
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Padded stream byte g = b*64+k: data, then 0x80, then zeros, with the bit
  // length in the last 8 bytes of the final block.
  function automatic logic [511:0] model_block(input int L, input int b);
    logic [511:0] r;
    int n, g;
    logic [63:0] bits;
    logic [7:0] v;
    n = ((L + 8) >> 6) + 1;
    bits = 64'(L) * 64'd8;
    r = '0;
    for (int k = 0; k < 64; k++) begin
      g = b * 64 + k;
      if (b == n - 1 && k >= 56) v = 8'(bits >> (8 * (63 - k)));
      else if (g < L)            v = mem[g];
      else if (g == L)           v = 8'h80;
      else                       v = 8'h00;
      r[511 - 8*k -: 8] = v;
    end
    return r;
  endfunction

  // Ready driver: 0 low, 1 high, 2 random, 3 left to the caller, 4 low for 10 cycles of valid.
  initial forever begin
    @(posedge clock); #1;
    case (rdy_mode)
      0: blk_ready = 1'b0;
      1: blk_ready = 1'b1;
      2: blk_ready = 1'($urandom_range(0, 1));
      4: blk_ready = (first_v >= 0) && (cyc >= first_v + 10);
      default: ;
    endcase
  end

  // Compare process: address sequence, block contents, hold stability, done.
  initial forever begin
    @(negedge clock);
    if (chk_en && reset_n) begin
      if (c_mem_en) begin
        check(c_mem_addr == LEN_W'(rd_exp) && rd_exp < cur_len, "mem_addr", c_mem_addr, rd_exp);
        rd_exp++;
      end
      if (c_valid) begin
        if (!held) begin
          if (exp_blk < nblk) begin
            check(c_data == model_block(cur_len, exp_blk), "blk_data", c_data, model_block(cur_len, exp_blk));
            check(c_last == (exp_blk == nblk - 1), "blk_last", c_last, (exp_blk == nblk - 1));
            cap_blk[exp_blk] = c_data;
          end else begin
            check(1'b0, "extra_block", exp_blk, nblk);
          end
          if (first_v < 0) first_v = cyc;
        end else begin
          check(c_data == prev_data, "hold_data", c_data, prev_data);
          check(c_last == prev_last, "hold_last", c_last, prev_last);
        end
        prev_data = c_data;
        prev_last = c_last;
        if (blk_ready && !abort) begin
          exp_blk++;
          held = 0;
        end else begin
          held = 1;
        end
      end else begin
        held = 0;
      end
      if (c_done) done_cnt++;
    end
  end

  task automatic arm(input int s, input int L, input int mode);
    sel = s; cur_len = L; nblk = ((L + 8) >> 6) + 1;
    exp_blk = 0; rd_exp = 0; first_v = -1; held = 0;
    rdy_mode = mode; chk_en = 1;
  endtask

  task automatic run_msg(input int s, input int L, input int mode, input bit rnd_mem);
    int lim, k, lat;
    bit got;
    if (rnd_mem) for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    @(posedge clock); #1;
    arm(s, L, mode);
    start = 1'b1; msg_len = LEN_W'(L); start_cyc = cyc;
    @(posedge clock); #1;
    start = 1'b0; msg_len = LEN_W'($urandom);
    lat = (s != 0) ? 3 : 1;
    lim = 300 * nblk + 100;
    got = 0;
    for (k = 0; k < lim && !got; k++) begin
      @(negedge clock);
      if (k == 0) check(c_busy, "busy_high", c_busy, 1);
      if (k == 2) begin start = 1'b1; msg_len = LEN_W'($urandom); end
      if (k == 3) start = 1'b0;
      if (c_done) got = 1;
    end
    if (!got) check(1'b0, "timeout", k, lim);
    check(exp_blk == nblk, "blocks_accepted", exp_blk, nblk);
    check(rd_exp == L, "read_count", rd_exp, L);
    check(!c_busy, "busy_low_at_done", c_busy, 0);
    if (L > 0)
      check(first_v - start_cyc == ((L < 64) ? L : 64) + lat + 3, "latency",
            first_v - start_cyc, ((L < 64) ? L : 64) + lat + 3);
    @(negedge clock);
    check(!c_done, "done_one_cycle", c_done, 0);
  endtask

  task automatic check_dut0_zero(input string tag);
    check(me0 == 1'b0, {tag, "_mem_en"}, me0, 0);
    check(ma0 == '0, {tag, "_mem_addr"}, ma0, 0);
    check(bv0 == 1'b0, {tag, "_blk_valid"}, bv0, 0);
    check(bd0 == '0, {tag, "_blk_data"}, bd0, 0);
    check(bl0 == 1'b0, {tag, "_blk_last"}, bl0, 0);
    check(bu0 == 1'b0, {tag, "_busy"}, bu0, 0);
    check(dn0 == 1'b0, {tag, "_done"}, dn0, 0);
  endtask

  initial begin
    int k, d0, L;
    bit got;
    #1 reset_n = 1'b0;
    #1 check_dut0_zero("reset");
    check(bu1 == 1'b0 && bv1 == 1'b0, "reset_dut1", {bu1, bv1}, 0);
    @(posedge clock); #3 reset_n = 1'b1;

    // "abc": pin the model against the hand-computed block, then the DUT.
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    check(model_block(3, 0) == ABC_LIT, "model_abc", model_block(3, 0), ABC_LIT);
    d0 = done_cnt;
    run_msg(0, 3, 1, 0);
    check(cap_blk[0] == ABC_LIT, "abc_block", cap_blk[0], ABC_LIT);
    check(done_cnt == d0 + 1, "abc_done_once", done_cnt - d0, 1);

    run_msg(0, 55, 2, 1);
    check(cap_blk[0][511 - 8*55 -: 8] == 8'h80, "len55_marker", cap_blk[0][511 - 8*55 -: 8], 8'h80);
    check(cap_blk[0][63:0] == 64'h1B8, "len55_length", cap_blk[0][63:0], 64'h1B8);

    run_msg(1, 56, 2, 1);
    check(cap_blk[1] == L56_B1, "len56_block1", cap_blk[1], L56_B1);
    check(cap_blk[0][511 - 8*56 -: 8] == 8'h80, "len56_marker", cap_blk[0][511 - 8*56 -: 8], 8'h80);

    check(model_block(0, 0) == L0_LIT, "model_len0", model_block(0, 0), L0_LIT);
    run_msg(0, 0, 1, 1);
    check(cap_blk[0] == L0_LIT, "len0_block", cap_blk[0], L0_LIT);

    run_msg(1, 64, 4, 1);
    check(cap_blk[1] == L64_B1, "len64_block1", cap_blk[1], L64_B1);

    // Reset pulse during FILL of a 100-byte message.
    for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
    @(posedge clock); #1;
    chk_en = 0; sel = 0; rdy_mode = 1;
    start = 1'b1; msg_len = LEN_W'(100);
    @(posedge clock); #1 start = 1'b0;
    repeat (10) @(posedge clock);
    #2 check(me0 == 1'b1 && bu0 == 1'b1, "fill_before_reset", {me0, bu0}, 2'b11);
    reset_n = 1'b0;
    #1 check_dut0_zero("midreset");
    @(posedge clock); #3 reset_n = 1'b1;

    // Abort while the block is presented, with ready high in the same cycle.
    mem[0] = 8'h61; mem[1] = 8'h62; mem[2] = 8'h63;
    @(posedge clock); #1;
    arm(0, 3, 3);
    blk_ready = 1'b0;
    start = 1'b1; msg_len = LEN_W'(3);
    @(posedge clock); #1 start = 1'b0;
    got = 0;
    for (k = 0; k < 50 && !got; k++) begin
      @(negedge clock);
      if (c_valid) got = 1;
    end
    check(got, "abort_wait_valid", got, 1);
    d0 = done_cnt;
    @(posedge clock); #1 abort = 1'b1; blk_ready = 1'b1;
    @(posedge clock); #1 abort = 1'b0; blk_ready = 1'b0;
    @(negedge clock);
    check(!c_valid && !c_busy && !c_mem_en, "abort_idle", {c_valid, c_busy, c_mem_en}, 0);
    repeat (4) @(negedge clock);
    check(done_cnt == d0, "no_done_after_abort", done_cnt - d0, 0);
    check(exp_blk == 0, "abort_not_accepted", exp_blk, 0);
    run_msg(0, 3, 1, 0);
    check(cap_blk[0] == ABC_LIT, "abc_after_abort", cap_blk[0], ABC_LIT);

    // Maximum length message.
    run_msg(0, 1023, 1, 1);

    // Randomized lengths, instances and ready patterns.
    for (int it = 0; it < 14; it++) begin
      case ($urandom_range(0, 3))
        0: L = 56 + 8 * $urandom_range(0, 8);
        1: L = 63 + $urandom_range(0, 2) * 64;
        default: L = $urandom_range(0, 200);
      endcase
      run_msg($urandom_range(0, 1), L, ($urandom_range(0, 2) == 0) ? 1 : 2, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
